// File: rtl/he_lb_csr_responder.sv
// HE-LB MMIO CSR responder: decodes host reads/writes, drives engine controls,
// accumulates engine status counters and returns tagged read completions.
module he_lb_csr_responder #(
  parameter logic [11:0]  FEAT_ID        = 12'h0,
  parameter logic [3:0]   AFU_MAJOR      = 4'h0,
  parameter logic [3:0]   AFU_MINOR      = 4'h0,
  parameter logic [23:0]  NXT_DFH_OFFSET = 24'h0,
  parameter logic         DFH_EOL        = 1'b1,
  parameter logic [127:0] AFU_ID         = 128'h0,
  parameter logic [15:0]  CLK_MHZ        = 16'd400,
  parameter logic [7:0]   API_VERSION    = 8'h1,
  parameter logic         ATOMICS        = 1'b0,
  parameter logic [1:0]   BUS_SHIFT      = 2'd1,
  parameter logic [4:0]   LMEM_SHIFT     = 5'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [15:0] wr_addr,
  input  logic        wr_size,
  input  logic [63:0] wr_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [15:0] rd_addr,
  input  logic        rd_size,
  input  logic [9:0]  rd_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [9:0]  rsp_tag,
  output logic        eng_rst_n,
  output logic        eng_start,
  output logic        eng_stop,
  output logic [63:0] src_addr,
  output logic [63:0] dst_addr,
  output logic [63:0] dsm_base,
  output logic [19:0] num_lines,
  output logic [31:0] cfg,
  input  logic        rd_line_inc,
  input  logic        wr_line_inc,
  input  logic [31:0] eng_error
);
  localparam int NRW = 11;
  localparam logic [63:0] DFH_VAL =
    {4'h1, 8'h0, AFU_MINOR, 7'h0, DFH_EOL, NXT_DFH_OFFSET, AFU_MAJOR, FEAT_ID};
  localparam logic [31:0] INFO0_VAL = {LMEM_SHIFT, BUS_SHIFT, ATOMICS, API_VERSION, CLK_MHZ};
  localparam logic [12:0] Q_CTL = 13'h027;

  // {hit, index} into the generic read/write register bank
  function automatic logic [4:0] rw_sel(input logic [12:0] q);
    case (q)
      13'h020: rw_sel = {1'b1, 4'd0};   // SP1:SP0
      13'h021: rw_sel = {1'b1, 4'd1};   // SP2
      13'h022: rw_sel = {1'b1, 4'd2};   // DSM
      13'h024: rw_sel = {1'b1, 4'd3};   // SRC
      13'h025: rw_sel = {1'b1, 4'd4};   // DST
      13'h026: rw_sel = {1'b1, 4'd5};   // NUM_LINES
      13'h028: rw_sel = {1'b1, 4'd6};   // CFG
      13'h029: rw_sel = {1'b1, 4'd7};   // INACT_THRESH
      13'h02A: rw_sel = {1'b1, 4'd8};   // INTERRUPT0
      13'h02B: rw_sel = {1'b1, 4'd9};   // SWTEST_MSG
      13'h02F: rw_sel = {1'b1, 4'd10};  // STRIDE
      default: rw_sel = 5'd0;
    endcase
  endfunction

  logic [NRW-1:0][63:0] rw_q, rw_d;
  logic        ctl0_q, ctl0_d, start_q, start_d, stop_q, stop_d, busy_q, busy_d;
  logic [31:0] rd_lines_q, rd_lines_d, wr_lines_q, wr_lines_d, busy_cnt_q, busy_cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_data_q, rsp_data_d, rq, rd_word;
  logic [9:0]  rsp_tag_q, rsp_tag_d;
  logic [4:0]  wsel, rsel;
  logic        ctl_wr, rd_acc;
  logic        unused_ok;

  assign unused_ok = ^{wr_addr[1:0], rd_addr[1:0]};

  // Register writes; a 32-bit write touches only the lane chosen by addr[2]
  always_comb begin
    rw_d = rw_q;
    wsel = rw_sel(wr_addr[15:3]);
    if (wr_valid && wsel[4])
      rw_d[wsel[3:0]] = wr_size ? wr_data :
                        wr_addr[2] ? {wr_data[31:0], rw_q[wsel[3:0]][31:0]}
                                   : {rw_q[wsel[3:0]][63:32], wr_data[31:0]};
  end

  // CTL control bits live in the low dword, so an upper-lane write leaves them alone
  assign ctl_wr  = wr_valid && (wr_addr[15:3] == Q_CTL) && (wr_size || !wr_addr[2]);
  assign ctl0_d  = ctl_wr ? wr_data[0] : ctl0_q;
  assign start_d = ctl_wr && wr_data[1] && wr_data[0];
  assign stop_d  = ctl_wr && wr_data[2];

  always_comb begin
    rd_lines_d = rd_lines_q + 32'(rd_line_inc);
    wr_lines_d = wr_lines_q + 32'(wr_line_inc);
    busy_cnt_d = busy_cnt_q + 32'(busy_q);
    busy_d     = busy_q;
    if (stop_q)       busy_d = 1'b0;
    else if (start_q) busy_d = 1'b1;
    if (!ctl0_q) begin
      rd_lines_d = '0;
      wr_lines_d = '0;
      busy_cnt_d = '0;
      busy_d     = 1'b0;
    end
  end

  // Read decode sees pre-write state, so a same-cycle write is not forwarded
  always_comb begin
    rq   = '0;
    rsel = rw_sel(rd_addr[15:3]);
    if (rsel[4]) rq = rw_q[rsel[3:0]];
    else begin
      case (rd_addr[15:3])
        13'h000: rq = DFH_VAL;
        13'h001: rq = AFU_ID[63:0];
        13'h002: rq = AFU_ID[127:64];
        Q_CTL:   rq = {63'h0, ctl0_q};
        13'h02C: rq = {wr_lines_q, rd_lines_q};
        13'h02D: rq = {32'h0, busy_cnt_q};
        13'h02E: rq = {32'h0, eng_error};
        13'h030: rq = {32'h0, INFO0_VAL};
        default: rq = '0;
      endcase
    end
  end

  assign rd_word = rd_size ? rq : (rd_addr[2] ? {2{rq[63:32]}} : {2{rq[31:0]}});
  assign rd_ready = !rsp_valid_q || rsp_ready;
  assign rd_acc   = rd_valid && rd_ready;

  always_comb begin
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    if (rd_acc) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rd_word;
      rsp_tag_d   = rd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q        <= '0;
      ctl0_q      <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      rd_lines_q  <= '0;
      wr_lines_q  <= '0;
      busy_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      rw_q        <= rw_d;
      ctl0_q      <= ctl0_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      rd_lines_q  <= rd_lines_d;
      wr_lines_q  <= wr_lines_d;
      busy_cnt_q  <= busy_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign eng_rst_n = ctl0_q;
  assign eng_start = start_q;
  assign eng_stop  = stop_q;
  assign dsm_base  = rw_q[2];
  assign src_addr  = rw_q[3];
  assign dst_addr  = rw_q[4];
  assign num_lines = rw_q[5][19:0];
  assign cfg       = rw_q[6][31:0];
endmodule

// File: tb/tb_he_lb_csr_responder.sv
// Directed bench for the HE-LB CSR responder: register map, lanes, controls,
// counters, backpressure and asynchronous reset.
module tb_he_lb_csr_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_size, rd_valid, rd_size, rsp_ready;
  logic [15:0] wr_addr, rd_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_tag;
  logic        rd_ready, rsp_valid;
  logic [63:0] rsp_data;
  logic [9:0]  rsp_tag;
  logic        eng_rst_n, eng_start, eng_stop;
  logic [63:0] src_addr, dst_addr, dsm_base;
  logic [19:0] num_lines;
  logic [31:0] cfg;
  logic        rd_line_inc, wr_line_inc;
  logic [31:0] eng_error;

  int n_pass = 0, n_total = 0;
  int start_cnt = 0, stop_cnt = 0;

  always #5 clk = ~clk;

  he_lb_csr_responder dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_size(rd_size),
    .rd_tag(rd_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .eng_rst_n(eng_rst_n), .eng_start(eng_start), .eng_stop(eng_stop),
    .src_addr(src_addr), .dst_addr(dst_addr), .dsm_base(dsm_base),
    .num_lines(num_lines), .cfg(cfg),
    .rd_line_inc(rd_line_inc), .wr_line_inc(wr_line_inc), .eng_error(eng_error)
  );

  always @(posedge clk) begin
    if (eng_start) start_cnt <= start_cnt + 1;
    if (eng_stop)  stop_cnt  <= stop_cnt + 1;
  end

  task automatic mmio_wr(input logic [15:0] a, input logic sz, input logic [63:0] d);
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = a; wr_size = sz; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Issue one read; returns the completion seen one cycle after acceptance
  task automatic mmio_rd(input logic [15:0] a, input logic sz, input logic [9:0] tg,
                         output logic [63:0] d, output logic [9:0] t, output logic ok);
    int n;
    @(negedge clk);
    rd_valid = 1'b1; rd_addr = a; rd_size = sz; rd_tag = tg;
    n = 0;
    while (!rd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rd_valid = 1'b0;
    ok = rsp_valid && (n < 20);
    d  = rsp_data;
    t  = rsp_tag;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); else n_pass++;
    n_total++; if (rd_ready !== 1'b1) $display("FAIL reset_rd_ready got %0b want 1", rd_ready); else n_pass++;
    n_total++; if (eng_rst_n !== 1'b0) $display("FAIL reset_eng_rst_n got %0b want 0", eng_rst_n); else n_pass++;
    n_total++; if ({src_addr, dst_addr, dsm_base} !== 192'h0 || num_lines !== 20'h0 || cfg !== 32'h0)
      $display("FAIL reset_cfg_outputs src %h dst %h dsm %h want 0", src_addr, dst_addr, dsm_base);
    else n_pass++;
  endtask

  task automatic test_dfh_info();
    logic [63:0] d; logic [9:0] t; logic ok;
    mmio_rd(16'h000, 1'b1, 10'h3A, d, t, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL dfh_latency rsp_valid got %0b want 1", ok); else n_pass++;
    n_total++; if (d !== 64'h1000_0100_0000_0000) $display("FAIL dfh_data got %h want 1000010000000000", d); else n_pass++;
    n_total++; if (t !== 10'h3A) $display("FAIL dfh_tag got %h want 03a", t); else n_pass++;
    mmio_rd(16'h180, 1'b1, 10'h3A, d, t, ok);
    n_total++; if (ok !== 1'b1 || d !== 64'h0000_0000_2201_0190)
      $display("FAIL info0_data got %h valid %0b want 0000000022010190", d, ok);
    else n_pass++;
    n_total++; if (t !== 10'h3A) $display("FAIL info0_tag got %h want 03a", t); else n_pass++;
    // read-only and unmapped writes are dropped
    mmio_wr(16'h000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    mmio_wr(16'h1F8, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5);
    mmio_rd(16'h000, 1'b1, 10'h001, d, t, ok);
    n_total++; if (d !== 64'h1000_0100_0000_0000) $display("FAIL dfh_ro got %h want 1000010000000000", d); else n_pass++;
    mmio_rd(16'h1F8, 1'b1, 10'h002, d, t, ok);
    n_total++; if (ok !== 1'b1 || d !== 64'h0) $display("FAIL unmapped_read got %h want 0", d); else n_pass++;
  endtask

  task automatic test_scratch();
    logic [63:0] d; logic [9:0] t; logic ok;
    mmio_wr(16'h104, 1'b0, 64'h0000_0000_DEAD_BEEF);
    mmio_wr(16'h100, 1'b0, 64'h0000_0000_1234_5678);
    mmio_rd(16'h100, 1'b1, 10'h010, d, t, ok);
    n_total++; if (d !== 64'hDEAD_BEEF_1234_5678) $display("FAIL sp_64 got %h want deadbeef12345678", d); else n_pass++;
    mmio_rd(16'h104, 1'b0, 10'h011, d, t, ok);
    n_total++; if (d !== 64'hDEAD_BEEF_DEAD_BEEF) $display("FAIL sp_32_hi got %h want deadbeefdeadbeef", d); else n_pass++;
    mmio_rd(16'h100, 1'b0, 10'h012, d, t, ok);
    n_total++; if (d !== 64'h1234_5678_1234_5678) $display("FAIL sp_32_lo got %h want 1234567812345678", d); else n_pass++;
    mmio_wr(16'h120, 1'b1, 64'h1122_3344_5566_7788);
    mmio_wr(16'h144, 1'b0, 64'h0000_0000_CAFE_0001);
    idle(1);
    n_total++; if (src_addr !== 64'h1122_3344_5566_7788) $display("FAIL src_out got %h want 1122334455667788", src_addr); else n_pass++;
    n_total++; if (cfg !== 32'h0) $display("FAIL cfg_upper_lane got %h want 0", cfg); else n_pass++;
  endtask

  task automatic test_start();
    logic [63:0] d; logic [9:0] t; logic ok;
    mmio_wr(16'h138, 1'b1, 64'h2);
    idle(2);
    n_total++; if (start_cnt !== 0) $display("FAIL start_gated got %0d want 0", start_cnt); else n_pass++;
    mmio_wr(16'h138, 1'b1, 64'h1);
    mmio_wr(16'h138, 1'b1, 64'h3);
    idle(2);
    n_total++; if (start_cnt !== 1) $display("FAIL start_pulse got %0d want 1", start_cnt); else n_pass++;
    n_total++; if (eng_rst_n !== 1'b1) $display("FAIL eng_rst_n_set got %0b want 1", eng_rst_n); else n_pass++;
    mmio_rd(16'h138, 1'b1, 10'h020, d, t, ok);
    n_total++; if (d !== 64'h1) $display("FAIL ctl_read got %h want 1", d); else n_pass++;
  endtask

  task automatic test_counters();
    logic [63:0] d; logic [9:0] t; logic ok;
    mmio_wr(16'h138, 1'b1, 64'h3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rd_line_inc = 1'b1; wr_line_inc = (i < 3);
    end
    @(negedge clk);
    rd_line_inc = 1'b0; wr_line_inc = 1'b0;
    mmio_wr(16'h138, 1'b1, 64'h5);
    idle(2);
    n_total++; if (start_cnt !== 2 || stop_cnt !== 1)
      $display("FAIL start_stop_cnt got %0d/%0d want 2/1", start_cnt, stop_cnt);
    else n_pass++;
    mmio_rd(16'h160, 1'b1, 10'h030, d, t, ok);
    n_total++; if (d !== 64'h0000_0003_0000_0005) $display("FAIL status0 got %h want 0000000300000005", d); else n_pass++;
    mmio_rd(16'h168, 1'b1, 10'h031, d, t, ok);
    n_total++; if (d[63:32] !== 32'h0 || d[31:0] == 32'h0) $display("FAIL status1_busy got %h want nonzero low dword", d); else n_pass++;
    eng_error = 32'h8000_0041;
    mmio_rd(16'h170, 1'b1, 10'h032, d, t, ok);
    n_total++; if (d !== 64'h0000_0000_8000_0041) $display("FAIL error_reg got %h want 0000000080000041", d); else n_pass++;
    // clear CTL with increments active through and after the write
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 16'h138; wr_size = 1'b1; wr_data = 64'h0;
    rd_line_inc = 1'b1; wr_line_inc = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    rd_line_inc = 1'b0; wr_line_inc = 1'b0;
    mmio_rd(16'h160, 1'b1, 10'h033, d, t, ok);
    n_total++; if (d !== 64'h0) $display("FAIL status0_clear got %h want 0", d); else n_pass++;
    mmio_rd(16'h168, 1'b1, 10'h034, d, t, ok);
    n_total++; if (d !== 64'h0) $display("FAIL status1_clear got %h want 0", d); else n_pass++;
    n_total++; if (eng_rst_n !== 1'b0) $display("FAIL eng_rst_n_clear got %0b want 0", eng_rst_n); else n_pass++;
  endtask

  task automatic test_back_to_back();
    mmio_wr(16'h108, 1'b1, 64'h0BAD_F00D_0000_0002);
    @(negedge clk);
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 16'h100; rd_size = 1'b1; rd_tag = 10'h011;
    @(negedge clk);
    rd_addr = 16'h108; rd_tag = 10'h022;
    n_total++; if (rsp_valid !== 1'b1 || rsp_tag !== 10'h011 || rsp_data !== 64'hDEAD_BEEF_1234_5678)
      $display("FAIL bp_first got v%0b tag %h data %h want v1 tag 011 deadbeef12345678", rsp_valid, rsp_tag, rsp_data);
    else n_pass++;
    n_total++; if (rd_ready !== 1'b0) $display("FAIL bp_rd_ready got %0b want 0", rd_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1 || rsp_tag !== 10'h011 || rsp_data !== 64'hDEAD_BEEF_1234_5678 || rd_ready !== 1'b0)
      $display("FAIL bp_hold got v%0b tag %h data %h rdy %0b want stable first", rsp_valid, rsp_tag, rsp_data, rd_ready);
    else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    n_total++; if (rsp_valid !== 1'b1 || rsp_tag !== 10'h022 || rsp_data !== 64'h0BAD_F00D_0000_0002)
      $display("FAIL bp_second got v%0b tag %h data %h want v1 tag 022 0badf00d00000002", rsp_valid, rsp_tag, rsp_data);
    else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL bp_drain got %0b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [63:0] d; logic [9:0] t; logic ok;
    @(negedge clk);
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 16'h120; rd_size = 1'b1; rd_tag = 10'h3FF;
    @(negedge clk);
    rd_valid = 1'b0;
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL ar_pending got %0b want 1", rsp_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL ar_immediate got %0b want 0", rsp_valid); else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_total++; if (rsp_valid !== 1'b0 || src_addr !== 64'h0) $display("FAIL ar_after got v%0b src %h want 0", rsp_valid, src_addr); else n_pass++;
    mmio_rd(16'h120, 1'b1, 10'h005, d, t, ok);
    n_total++; if (ok !== 1'b1 || d !== 64'h0) $display("FAIL ar_src_read got %h want 0", d); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_size = 1'b0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; rd_size = 1'b0; rd_tag = '0;
    rsp_ready = 1'b1; rd_line_inc = 1'b0; wr_line_inc = 1'b0; eng_error = '0;
    idle(3);
    test_reset();
    rst_n = 1'b1;
    test_dfh_info();
    test_scratch();
    test_start();
    test_counters();
    test_back_to_back();
    test_async_reset();
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
